// File: rtl/cd_sector_fetch.sv
// Purpose : fetch one raw CD sector per request from the HPS and replay it as a 16-bit
//           valid/ready stream with a last marker; flags short and long sectors.
// Latency : sector_req -> cd_hps_req next cycle; pushed word -> out_valid next cycle.
// Backpr. : out_ready stalls only the FIFO head; the HPS side cannot be stalled, so
//           words arriving when they cannot be stored are dropped and flagged.
//
// Ports:
//   clk30, reset_n                     clock, async active-low reset
//   sector_req, sector_lba, busy       request side (busy until sector fully drained)
//   cd_hps_lba, cd_hps_req, cd_hps_ack HPS request handshake
//   cd_hps_data_valid, cd_hps_data     HPS word stream (not back-pressurable)
//   out_valid, out_ready, out_data, out_last   registered FIFO head stream
//   fail_not_enough_words, fail_too_much_data  sticky error flags
//   sync_error                         sticky sync-header mismatch flag
//
// Build option: define CD_SECTOR_SYNC_CHECK_EN to compare words 0..5 of every sector
// against the CD sync pattern; otherwise sync_error is tied low.
module cd_sector_fetch #(
    parameter int WORDS_PER_SECTOR = 1176,
    parameter int FIFO_DEPTH       = 2048,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic        clk30,
    input  logic        reset_n,
    input  logic        sector_req,
    input  logic [31:0] sector_lba,
    output logic        busy,
    output logic [31:0] cd_hps_lba,
    output logic        cd_hps_req,
    input  logic        cd_hps_ack,
    input  logic        cd_hps_data_valid,
    input  logic [15:0] cd_hps_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        fail_not_enough_words,
    output logic        fail_too_much_data,
    output logic        sync_error
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WCW = $clog2(WORDS_PER_SECTOR + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DRAIN} state_t;

    state_t          state_q;
    logic            busy_q;
    logic            req_q;
    logic [31:0]     lba_q;
    logic [WCW-1:0]  word_cnt_q;
    logic [TCW-1:0]  to_cnt_q;
    logic            fail_ne_q;
    logic            fail_tm_q;

    // FIFO storage behind the registered head
    logic [16:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     mem_cnt_q, mem_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    logic            in_recv;
    logic            push_req;
    logic            push_last;
    logic            timeout_hit;
    logic            mem_full;
    logic            push_ok;
    logic            push_drop;
    logic            pop;
    logic            head_free;
    logic            mem_rd;
    logic            bypass;
    logic            mem_wr;
    logic            mark_mem;
    logic            mark_head;
    logic            fifo_empty;
    logic [AW-1:0]   tail_idx;

    assign in_recv     = (state_q == S_RECV);
    assign push_req    = in_recv && cd_hps_data_valid;
    assign push_last   = (word_cnt_q == WCW'(WORDS_PER_SECTOR - 1));
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle in RECV
    assign timeout_hit = in_recv && !cd_hps_data_valid
                         && (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
    assign mem_full    = (mem_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign push_ok     = push_req && !mem_full;
    assign push_drop   = push_req && mem_full;
    assign pop         = out_valid_q && out_ready;
    assign head_free   = !out_valid_q || pop;
    assign mem_rd      = head_free && (mem_cnt_q != '0);
    // With empty storage and a free head, a new word goes straight into the head
    assign bypass      = head_free && (mem_cnt_q == '0) && push_ok;
    assign mem_wr      = push_ok && !bypass;
    assign tail_idx    = wr_ptr_q - AW'(1);
    // Timeout marks the newest queued word as last, wherever it currently sits
    assign mark_mem    = timeout_hit && (mem_cnt_q != '0);
    assign mark_head   = timeout_hit && (mem_cnt_q == '0) && out_valid_q && !pop;
    assign fifo_empty  = !out_valid_q && (mem_cnt_q == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (mem_rd) begin
            out_valid_d = 1'b1;
            {out_last_d, out_data_d} = mem_q[rd_ptr_q];
            // Tail being marked is the very entry moving into the head this cycle
            if (mark_mem && (mem_cnt_q == (AW+1)'(1))) begin
                out_last_d = 1'b1;
            end
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = cd_hps_data;
            out_last_d  = push_last;
        end else if (head_free) begin
            out_valid_d = 1'b0;
        end else if (mark_head) begin
            out_last_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d  = mem_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = mem_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
    end

    // Storage array carries no reset; pointers define its contents
    always_ff @(posedge clk30) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= {push_last, cd_hps_data};
        end
        if (mark_mem) begin
            mem_q[tail_idx][16] <= 1'b1;
        end
    end

    always_ff @(posedge clk30 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef CD_SECTOR_SYNC_CHECK_EN
    logic sync_error_q;
    logic sync_mismatch;

    function automatic logic [15:0] sync_word(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFF00;
            3'd5:    return 16'h00FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign sync_mismatch = push_req && (word_cnt_q < WCW'(6))
                           && (cd_hps_data != sync_word(word_cnt_q[2:0]));
    assign sync_error    = sync_error_q;
`else
    assign sync_error = 1'b0;
`endif

    always_ff @(posedge clk30 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            lba_q      <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            fail_ne_q  <= 1'b0;
            fail_tm_q  <= 1'b0;
`ifdef CD_SECTOR_SYNC_CHECK_EN
            sync_error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sector_req) begin
                        state_q    <= S_REQ;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        lba_q      <= sector_lba;
                        word_cnt_q <= '0;
                        to_cnt_q   <= '0;
                        fail_ne_q  <= 1'b0;
                        fail_tm_q  <= 1'b0;
`ifdef CD_SECTOR_SYNC_CHECK_EN
                        sync_error_q <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (cd_hps_ack) begin
                        state_q <= S_RECV;
                        req_q   <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (cd_hps_data_valid) begin
                        word_cnt_q <= word_cnt_q + WCW'(1);
                        to_cnt_q   <= '0;
                        if (push_last) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (timeout_hit) begin
                        fail_ne_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else begin
                        to_cnt_q <= to_cnt_q + TCW'(1);
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Words outside RECV (including after the final word) or into a full
            // FIFO are lost; placed after the case so setting beats clearing.
            if ((cd_hps_data_valid && !in_recv) || push_drop) begin
                fail_tm_q <= 1'b1;
            end
`ifdef CD_SECTOR_SYNC_CHECK_EN
            if (sync_mismatch) begin
                sync_error_q <= 1'b1;
            end
`endif
        end
    end

    assign busy                  = busy_q;
    assign cd_hps_req            = req_q;
    assign cd_hps_lba            = lba_q;
    assign out_valid             = out_valid_q;
    assign out_data              = out_data_q;
    assign out_last              = out_last_q;
    assign fail_not_enough_words = fail_ne_q;
    assign fail_too_much_data    = fail_tm_q;

endmodule

// File: tb/tb_cd_sector_fetch.sv
module tb_cd_sector_fetch;

    localparam int WPS = 1176;
    localparam int TO  = 300;

    logic        clk30 = 1'b0;
    logic        reset_n;
    logic        sector_req;
    logic [31:0] sector_lba;
    logic        busy;
    logic [31:0] cd_hps_lba;
    logic        cd_hps_req;
    logic        cd_hps_ack;
    logic        cd_hps_data_valid;
    logic [15:0] cd_hps_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        fail_not_enough_words;
    logic        fail_too_much_data;
    logic        sync_error;

    int checks = 0;
    int errors = 0;
    logic [16:0] rx [$];

    always #5 clk30 = ~clk30;

    cd_sector_fetch #(
        .WORDS_PER_SECTOR(WPS),
        .FIFO_DEPTH      (2048),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk30                (clk30),
        .reset_n              (reset_n),
        .sector_req           (sector_req),
        .sector_lba           (sector_lba),
        .busy                 (busy),
        .cd_hps_lba           (cd_hps_lba),
        .cd_hps_req           (cd_hps_req),
        .cd_hps_ack           (cd_hps_ack),
        .cd_hps_data_valid    (cd_hps_data_valid),
        .cd_hps_data          (cd_hps_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data),
        .out_last             (out_last),
        .fail_not_enough_words(fail_not_enough_words),
        .fail_too_much_data   (fail_too_much_data),
        .sync_error           (sync_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record a word if it is handed over at the coming edge, then step to 1 ns after it
    task automatic cycle();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            rx.push_back({out_last, out_data});
        end
        @(posedge clk30);
        #1;
    endtask

    function automatic logic [15:0] word_val(input int i, input bit sync, input bit bad);
        if (sync && i < 6) begin
            case (i)
                0:       return 16'hFF00;
                3:       return bad ? 16'hFFFE : 16'hFFFF;
                5:       return 16'h00FF;
                default: return 16'hFFFF;
            endcase
        end
        return 16'(i);
    endfunction

    task automatic request(input logic [31:0] lba);
        rx.delete();
        sector_lba = lba;
        sector_req = 1'b1;
        cycle();
        sector_req = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) cycle();
        cd_hps_ack = 1'b1;
        cycle();
        cd_hps_ack = 1'b0;
    endtask

    task automatic send(input int first, input int n, input bit sync, input bit bad);
        for (int i = first; i < first + n; i++) begin
            cd_hps_data_valid = 1'b1;
            cd_hps_data       = word_val(i, sync, bad);
            cycle();
        end
        cd_hps_data_valid = 1'b0;
        cd_hps_data       = '0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 4000 && busy; k++) cycle();
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic check_rx(input string tag, input int n, input bit sync, input bit bad);
        int nbad;
        logic [16:0] e;
        nbad = 0;
        check({tag, "_count"}, rx.size(), n);
        for (int i = 0; i < rx.size(); i++) begin
            e[16]   = (i == n - 1);
            e[15:0] = word_val(i, sync, bad);
            if (rx[i] !== e) nbad++;
        end
        check({tag, "_order_last"}, nbad, 0);
    endtask

    initial begin
        reset_n           = 1'b0;
        sector_req        = 1'b0;
        sector_lba        = '0;
        cd_hps_ack        = 1'b0;
        cd_hps_data_valid = 1'b0;
        cd_hps_data       = '0;
        out_ready         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk30);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(cd_hps_req), 0);
        check("rst_lba", cd_hps_lba, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_fail_ne", 32'(fail_not_enough_words), 0);
        check("rst_fail_tm", 32'(fail_too_much_data), 0);
        reset_n = 1'b1;
        cycle();

        // 1: full sector, consumer always ready
        request(32'h10);
        check("t1_req", 32'(cd_hps_req), 1);
        check("t1_lba", cd_hps_lba, 32'h10);
        check("t1_busy", 32'(busy), 1);
        repeat (3) cycle();
        check("t1_req_held", 32'(cd_hps_req), 1);
        cd_hps_ack = 1'b1;
        cycle();
        cd_hps_ack = 1'b0;
        check("t1_req_drop", 32'(cd_hps_req), 0);
        out_ready = 1'b1;
        send(0, WPS, 0, 0);
        drain("t1");
        check_rx("t1", WPS, 0, 0);
        check("t1_fail_ne", 32'(fail_not_enough_words), 0);
        check("t1_fail_tm", 32'(fail_too_much_data), 0);
`ifndef CD_SECTOR_SYNC_CHECK_EN
        check("t1_sync", 32'(sync_error), 0);
`endif

        // 2: consumer stalled during fill
        request(32'h11);
        ack_after(3);
        out_ready = 1'b0;
        send(0, 1, 0, 0);
        check("t2_first_vld", 32'(out_valid), 1);
        check("t2_first_dat", 32'(out_data), 0);
        send(1, WPS - 1, 0, 0);
        repeat (5) cycle();
        check("t2_hold_vld", 32'(out_valid), 1);
        check("t2_hold_dat", 32'(out_data), 0);
        drain("t2");
        check_rx("t2", WPS, 0, 0);
        check("t2_fail_tm", 32'(fail_too_much_data), 0);

        // 3: short sector, timeout
        request(32'h12);
        ack_after(3);
        out_ready = 1'b0;
        send(0, 1000, 0, 0);
        repeat (TO - 1) cycle();
        check("t3_fail_ne_early", 32'(fail_not_enough_words), 0);
        cycle();
        check("t3_fail_ne", 32'(fail_not_enough_words), 1);
        check("t3_busy_drain", 32'(busy), 1);
        drain("t3");
        check_rx("t3", 1000, 0, 0);
        check("t3_fail_tm", 32'(fail_too_much_data), 0);

        // 4: long sector, extra words dropped
        request(32'h13);
        check("t4_fail_ne_clr", 32'(fail_not_enough_words), 0);
        ack_after(3);
        out_ready = 1'b1;
        send(0, WPS + 4, 0, 0);
        drain("t4");
        check_rx("t4", WPS, 0, 0);
        check("t4_fail_tm", 32'(fail_too_much_data), 1);

        // 5: async reset in the middle of a sector
        request(32'h14);
        check("t5_fail_tm_clr", 32'(fail_too_much_data), 0);
        ack_after(3);
        send(0, 500, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_req", 32'(cd_hps_req), 0);
        check("t5_rst_vld", 32'(out_valid), 0);
        check("t5_rst_lba", cd_hps_lba, 0);
        @(negedge clk30);
        reset_n = 1'b1;
        cycle();
        check("t5_empty", 32'(out_valid), 0);
        request(32'h15);
        check("t5_lba", cd_hps_lba, 32'h15);
        ack_after(2);
        send(0, WPS, 0, 0);
        drain("t5");
        check_rx("t5", WPS, 0, 0);

        // 6: sync header
        request(32'h16);
        ack_after(3);
        send(0, WPS, 1, 1);
        drain("t6_bad");
        check_rx("t6_bad", WPS, 1, 1);
`ifdef CD_SECTOR_SYNC_CHECK_EN
        check("t6_sync_bad", 32'(sync_error), 1);
        request(32'h17);
        check("t6_sync_clr", 32'(sync_error), 0);
        ack_after(3);
        send(0, WPS, 1, 0);
        drain("t6_good");
        check("t6_sync_good", 32'(sync_error), 0);
`else
        check("t6_sync_tied", 32'(sync_error), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
